// File: rtl/rom_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rom_port_arbiter
// Brief    : Two-requester arbiter in front of the single picture-ROM port,
//            four-phase handshake on both sides with a hung-ROM timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] data1,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_wait_ack   = 3'd1;
  localparam logic [2:0] c_st_hold       = 3'd2;
  localparam logic [2:0] c_st_hold_abort = 3'd3;
  localparam logic [2:0] c_st_release    = 3'd4;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any_req;
  logic             w_grant;
  logic             w_owner_req;
  logic             w_timeout_hit;

  assign w_any_req     = req0 | req1;
  // On a tie the fixed mode favours 0; round-robin hands it to whoever lost last.
  assign w_grant       = (req0 & req1) ? (FIXED_PRIO ? 1'b0 : ~r_last_grant) : req1;
  assign w_owner_req   = owner ? req1 : req0;
  assign w_timeout_hit = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:       if (w_any_req) w_state_next = c_st_wait_ack;
      c_st_wait_ack: begin
        if (rom_ack)            w_state_next = c_st_hold;
        else if (w_timeout_hit) w_state_next = c_st_hold_abort;
      end
      c_st_hold,
      c_st_hold_abort: if (!w_owner_req) w_state_next = c_st_release;
      c_st_release:    if (!rom_ack) w_state_next = c_st_idle;
      default:         w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
  end

  // Registered datapath: every handshake output is a flop, updated per state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      data0        <= '0;
      data1        <= '0;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      owner        <= 1'b0;
      timeout_err  <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any_req) begin
            owner        <= w_grant;
            r_last_grant <= w_grant;
            rom_addr     <= w_grant ? addr1 : addr0;
            rom_req      <= 1'b1;
            r_cnt        <= '0;
          end
        end
        c_st_wait_ack: begin
          if (rom_ack) begin
            if (owner) begin
              data1 <= rom_data;
              ack1  <= 1'b1;
            end else begin
              data0 <= rom_data;
              ack0  <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            if (owner) begin
              data1 <= '0;
              ack1  <= 1'b1;
            end else begin
              data0 <= '0;
              ack0  <= 1'b1;
            end
            timeout_err <= 1'b1;
            rom_req     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_st_hold: begin
          if (!w_owner_req) begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rom_req <= 1'b0;
          end
        end
        c_st_hold_abort: begin
          if (!w_owner_req) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_rom_port_arbiter
// Brief    : Directed self-checking bench; instance 0 round-robin, instance 1
//            fixed priority, both with a 16-cycle timeout and a ROM responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 [2];
  logic       req1 [2];
  logic [6:0] addr0 [2];
  logic [6:0] addr1 [2];
  logic       ack0 [2];
  logic       ack1 [2];
  logic [7:0] data0 [2];
  logic [7:0] data1 [2];
  logic       rom_req [2];
  logic [6:0] rom_addr [2];
  logic       rom_ack [2];
  logic [7:0] rom_data [2];
  logic       busy [2];
  logic       owner [2];
  logic       timeout_err [2];

  logic       rom_en [2];
  int         rcnt [2];
  int         ack_dly = 2;
  int         rel_dly = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_W(7), .DATA_W(8), .FIXED_PRIO(1'b0), .TIMEOUT(16), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .addr0(addr0[0]), .ack0(ack0[0]), .data0(data0[0]),
    .req1(req1[0]), .addr1(addr1[0]), .ack1(ack1[0]), .data1(data1[0]),
    .rom_req(rom_req[0]), .rom_addr(rom_addr[0]), .rom_ack(rom_ack[0]), .rom_data(rom_data[0]),
    .busy(busy[0]), .owner(owner[0]), .timeout_err(timeout_err[0])
  );

  rom_port_arbiter #(.ADDR_W(7), .DATA_W(8), .FIXED_PRIO(1'b1), .TIMEOUT(16), .CNT_W(8)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .addr0(addr0[1]), .ack0(ack0[1]), .data0(data0[1]),
    .req1(req1[1]), .addr1(addr1[1]), .ack1(ack1[1]), .data1(data1[1]),
    .rom_req(rom_req[1]), .rom_addr(rom_addr[1]), .rom_ack(rom_ack[1]), .rom_data(rom_data[1]),
    .busy(busy[1]), .owner(owner[1]), .timeout_err(timeout_err[1])
  );

  function automatic logic [7:0] rom_image(input logic [6:0] a);
    return (a == 7'h2A) ? 8'hC5 : ({a, 1'b1} ^ 8'h3C);
  endfunction

  // ROM controller stand-in: ack follows req after ack_dly/rel_dly extra cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || !rom_en[d]) begin
        rom_ack[d] <= 1'b0;
        rcnt[d]    <= 0;
      end else if (rom_req[d] != rom_ack[d]) begin
        if (rcnt[d] >= (rom_req[d] ? ack_dly : rel_dly)) begin
          rom_ack[d] <= rom_req[d];
          if (rom_req[d]) rom_data[d] <= rom_image(rom_addr[d]);
          rcnt[d] <= 0;
        end else begin
          rcnt[d] <= rcnt[d] + 1;
        end
      end else begin
        rcnt[d] <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int d, input int sel);
    case (sel)
      0:       return ack0[d];
      1:       return ack1[d];
      2:       return busy[d];
      3:       return rom_req[d];
      default: return owner[d];
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int d, input int sel, input logic val,
                          input int budget, output int cycles);
    cycles = 0;
    while (sig(d, sel) !== val && cycles < budget) begin
      tick();
      cycles++;
    end
    if (sig(d, sel) !== val) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic set_req(input int d, input int n, input logic v);
    if (n == 0) req0[d] = v;
    else        req1[d] = v;
  endtask

  // Both requesters re-request as soon as their ack drops; records the first six grants.
  task automatic rr_run(input int d, output logic [5:0] seq);
    int got;
    int cyc;
    int cw;
    int issued [2];
    got = 0;
    cyc = 0;
    seq = '0;
    issued[0] = req0[d] ? 1 : 0;
    issued[1] = req1[d] ? 1 : 0;
    while (got < 6 && cyc < 400) begin
      tick();
      cyc++;
      for (int n = 0; n < 2; n++) begin
        logic r;
        logic a;
        r = (n == 0) ? req0[d] : req1[d];
        a = (n == 0) ? ack0[d] : ack1[d];
        if (r && a) begin
          if (got < 6) seq[got] = (n == 1);
          got++;
          set_req(d, n, 1'b0);
        end else if (!r && !a && issued[n] < 6) begin
          set_req(d, n, 1'b1);
          issued[n]++;
        end
      end
    end
    check("rr_six_grants", (got >= 6), 32'd1);
    req0[d] = 1'b0;
    req1[d] = 1'b0;
    wait_sig("rr_drain", d, 2, 1'b0, 100, cw);
  endtask

  initial begin
    int cyc;
    int busy_low;
    logic [5:0] seq;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; req1[d] = 1'b0;
      addr0[d] = '0;  addr1[d] = '0;
      rom_en[d] = 1'b1;
    end
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack0", ack0[0], 0);
    check("rst_ack1", ack1[0], 0);
    check("rst_data0", data0[0], 0);
    check("rst_data1", data1[0], 0);
    check("rst_rom_req", rom_req[0], 0);
    check("rst_rom_addr", rom_addr[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_owner", owner[0], 0);
    check("rst_terr", timeout_err[0], 0);
    rst = 1'b0;
    tick();

    // Single read by requester 0, ROM answers three cycles after rom_req.
    req0[0] = 1'b1; addr0[0] = 7'h2A;
    tick();
    check("a_rom_req", rom_req[0], 1);
    check("a_rom_addr", rom_addr[0], 7'h2A);
    check("a_owner", owner[0], 0);
    wait_sig("a_ack0", 0, 0, 1'b1, 20, cyc);
    check("a_ack_latency", cyc, 4);
    check("a_data0", data0[0], 8'hC5);
    check("a_ack1", ack1[0], 0);
    tick();
    check("a_rom_req_held", rom_req[0], 1);
    req0[0] = 1'b0;
    tick();
    check("a_rom_req_fall", rom_req[0], 0);
    check("a_ack0_fall", ack0[0], 0);
    wait_sig("a_idle", 0, 2, 1'b0, 20, cyc);
    check("a_data0_kept", data0[0], 8'hC5);

    // Hung ROM: abort after 16 cycles in WAIT_ACK.
    rom_en[0] = 1'b0;
    req0[0] = 1'b1; addr0[0] = 7'h11;
    tick();
    check("t_rom_req", rom_req[0], 1);
    wait_sig("t_abort", 0, 3, 1'b0, 40, cyc);
    check("t_cycles", cyc, 16);
    check("t_ack0", ack0[0], 1);
    check("t_data0", data0[0], 8'h00);
    check("t_terr", timeout_err[0], 1);
    check("t_busy", busy[0], 1);
    req0[0] = 1'b0;
    wait_sig("t_idle", 0, 2, 1'b0, 20, cyc);
    rom_en[0] = 1'b1;

    // Requester 1 arrives while requester 0 is in HOLD.
    req0[0] = 1'b1; addr0[0] = 7'h33;
    wait_sig("q_ack0", 0, 0, 1'b1, 20, cyc);
    check("q_data0", data0[0], 8'h5B);
    check("q_terr_sticky", timeout_err[0], 1);
    req1[0] = 1'b1; addr1[0] = 7'h05;
    tick(); tick(); tick();
    check("q_addr_hold", rom_addr[0], 7'h33);
    check("q_ack1_low", ack1[0], 0);
    req0[0] = 1'b0;
    tick();
    check("q_addr_release", rom_addr[0], 7'h33);
    wait_sig("q_grant1", 0, 4, 1'b1, 20, cyc);
    check("q_grant_cycles", cyc, 3);
    check("q_addr1", rom_addr[0], 7'h05);
    check("q_rom_req1", rom_req[0], 1);
    wait_sig("q_ack1", 0, 1, 1'b1, 20, cyc);
    check("q_data1", data1[0], 8'h37);
    check("q_data0_kept", data0[0], 8'h5B);
    check("q_ack0_low", ack0[0], 0);
    req1[0] = 1'b0;
    wait_sig("q_idle", 0, 2, 1'b0, 20, cyc);

    // Slow release on both sides.
    rel_dly = 3;
    req0[0] = 1'b1; addr0[0] = 7'h12;
    wait_sig("s_ack0", 0, 0, 1'b1, 20, cyc);
    check("s_data0", data0[0], 8'h19);
    busy_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy[0] !== 1'b1) busy_low++;
    end
    check("s_busy_hold", busy_low, 0);
    req0[0] = 1'b0;
    tick();
    check("s_rom_req_fall", rom_req[0], 0);
    wait_sig("s_idle", 0, 2, 1'b0, 20, cyc);
    check("s_idle_cycles", cyc, 5);
    check("s_rom_ack_low", rom_ack[0], 0);
    rel_dly = 0;

    // Reset pulse while requester 1 waits on a silent ROM.
    rom_en[0] = 1'b0;
    req1[0] = 1'b1; addr1[0] = 7'h12;
    tick(); tick();
    check("r_pre_owner", owner[0], 1);
    rst = 1'b1;
    tick();
    check("r_busy", busy[0], 0);
    check("r_rom_req", rom_req[0], 0);
    check("r_rom_addr", rom_addr[0], 0);
    check("r_owner", owner[0], 0);
    check("r_data0", data0[0], 0);
    check("r_data1", data1[0], 0);
    check("r_terr", timeout_err[0], 0);
    rst = 1'b0;
    rom_en[0] = 1'b1;
    req0[0] = 1'b1; addr0[0] = 7'h44;
    tick();
    check("r_first_owner", owner[0], 0);
    check("r_first_addr", rom_addr[0], 7'h44);

    // Continuous contention: alternation, then fixed priority on the other instance.
    rr_run(0, seq);
    check("rr_sequence", seq, 6'b101010);
    req0[1] = 1'b1; req1[1] = 1'b1;
    rr_run(1, seq);
    check("fp_sequence", seq, 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
